// File: rtl/reflet_float_latency_tracker.sv
// Operand-settle tracker for the FPU datapath.
// Watches the operand bus and the operation select; after any change it counts
// clock cycles up to the latency of the currently selected operation and then
// flags the result as ready. Ready drops combinationally in the very cycle an
// input changes, so a stale result is never reported as valid.
//
// Handshake: ready is a level, valid for the current in/op while enable is high
// and the inputs have not changed since the last edge; ready_pulse marks only
// its rising edge; busy is its complement while enabled. Nothing is held back
// by the consumer: there is no back-pressure input.
module reflet_float_latency_tracker #(
  parameter int INPUT_SIZE = 16,
  parameter int OP_WIDTH   = 2,
  parameter int LAT_WIDTH  = 4,
  parameter logic [(2**OP_WIDTH)*LAT_WIDTH-1:0] LATENCIES = 16'h3210
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [INPUT_SIZE-1:0] in,
  input  logic [OP_WIDTH-1:0]   op,
  output logic                  ready,
  output logic                  ready_pulse,
  output logic                  busy,
  output logic [LAT_WIDTH-1:0]  remaining
);

  localparam int NUM_OPS = 2**OP_WIDTH;

  logic [INPUT_SIZE-1:0] prev_in;
  logic [OP_WIDTH-1:0]   prev_op;
  logic [LAT_WIDTH-1:0]  counter;
  logic                  ready_q;

  logic [LAT_WIDTH-1:0]  lat_table [NUM_OPS];
  logic [LAT_WIDTH-1:0]  target;
  logic                  changed;

  // Unpack the latency table so the current op can index it directly.
  for (genvar i = 0; i < NUM_OPS; i++) begin : g_lat
    assign lat_table[i] = LATENCIES[i*LAT_WIDTH +: LAT_WIDTH];
  end

  // Change detection and latency lookup (target follows the current op).
  always_comb begin
    changed = (in != prev_in) || (op != prev_op);
    target  = lat_table[op];
  end

  // State update: history registers, saturating settle counter, ready history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_in <= '0;
      prev_op <= '0;
      counter <= '0;
      ready_q <= 1'b0;
    end else begin
      prev_in <= in;
      prev_op <= op;
      ready_q <= ready;
      if (!enable) begin
        counter <= '0;
      end else if (changed) begin
        // The sampling cycle itself is the first elapsed cycle.
        counter <= LAT_WIDTH'(1);
      end else if (counter < target) begin
        counter <= counter + LAT_WIDTH'(1);
      end
    end
  end

  // Status outputs; all forced low while reset is held.
  always_comb begin
    ready       = 1'b0;
    ready_pulse = 1'b0;
    busy        = 1'b0;
    remaining   = '0;
    if (reset && enable) begin
      if (target == '0) begin
        ready = 1'b1;
      end else begin
        ready = !changed && (counter >= target);
      end
      ready_pulse = ready && !ready_q;
      busy        = !ready;
      if (ready) begin
        remaining = '0;
      end else if (changed) begin
        remaining = target;
      end else begin
        remaining = target - counter;
      end
    end
  end

endmodule

// File: tb/tb_reflet_float_latency_tracker.sv
// Directed bench for reflet_float_latency_tracker: a default-table instance
// (latencies 0/1/2/3) and a 2-bit saturation instance (all latencies 3),
// both driven from the same inputs. Inputs change 1ns after a rising edge,
// outputs are checked 3ns after that, well clear of the next edge.
module tb_reflet_float_latency_tracker;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] in_bus;
  logic [1:0]  op;

  logic        ready_a, pulse_a, busy_a;
  logic [3:0]  rem_a;
  logic        ready_b, pulse_b, busy_b;
  logic [1:0]  rem_b;

  int checks = 0;
  int errors = 0;

  reflet_float_latency_tracker dut_a (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .in          (in_bus),
    .op          (op),
    .ready       (ready_a),
    .ready_pulse (pulse_a),
    .busy        (busy_a),
    .remaining   (rem_a)
  );

  reflet_float_latency_tracker #(
    .INPUT_SIZE (16),
    .OP_WIDTH   (2),
    .LAT_WIDTH  (2),
    .LATENCIES  (8'hFF)
  ) dut_b (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .in          (in_bus),
    .op          (op),
    .ready       (ready_b),
    .ready_pulse (pulse_b),
    .busy        (busy_b),
    .remaining   (rem_b)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "time limit reached");
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic r, input logic p, input logic b, input logic [3:0] rem);
    chk({tag, ".ready"},       32'(ready_a), 32'(r));
    chk({tag, ".ready_pulse"}, 32'(pulse_a), 32'(p));
    chk({tag, ".busy"},        32'(busy_a),  32'(b));
    chk({tag, ".remaining"},   32'(rem_a),   32'(rem));
  endtask

  task automatic chk_b(input string tag, input logic r, input logic p, input logic b, input logic [1:0] rem);
    chk({tag, ".b_ready"},       32'(ready_b), 32'(r));
    chk({tag, ".b_ready_pulse"}, 32'(pulse_b), 32'(p));
    chk({tag, ".b_busy"},        32'(busy_b),  32'(b));
    chk({tag, ".b_remaining"},   32'(rem_b),   32'(rem));
  endtask

  initial begin
    // Reset held two cycles with a busy-looking bus: everything low.
    reset = 1'b0; enable = 1'b1; in_bus = 16'hFFFF; op = 2'd2;
    cyc(); settle(); chk_a("rst0", 0, 0, 0, 0); chk_b("rst0", 0, 0, 0, 0);
    cyc(); settle(); chk_a("rst1", 0, 0, 0, 0);

    // Release: prev_in is 0, so the first sampled cycle is a change (op2, target 2).
    cyc(); reset = 1'b1; settle(); chk_a("rel_chg", 0, 0, 1, 2);
    cyc(); settle(); chk_a("rel_e1", 0, 0, 1, 1);
    cyc(); settle(); chk_a("rel_e2", 1, 1, 0, 0);
    cyc(); settle(); chk_a("rel_e3", 1, 0, 0, 0);

    // Latency sweep with in held at 1234.
    cyc(); in_bus = 16'h1234; op = 2'd0; settle(); chk_a("op0", 1, 0, 0, 0);
    cyc(); op = 2'd1; settle(); chk_a("op1_chg", 0, 0, 1, 1);
    cyc(); settle(); chk_a("op1_e1", 1, 1, 0, 0);
    cyc(); op = 2'd2; settle(); chk_a("op2_chg", 0, 0, 1, 2);
    cyc(); settle(); chk_a("op2_e1", 0, 0, 1, 1);
    cyc(); settle(); chk_a("op2_e2", 1, 1, 0, 0);
    cyc(); op = 2'd3; settle(); chk_a("op3_chg", 0, 0, 1, 3);
    cyc(); settle(); chk_a("op3_e1", 0, 0, 1, 2);
    cyc(); settle(); chk_a("op3_e2", 0, 0, 1, 1);
    cyc(); settle(); chk_a("op3_e3", 1, 1, 0, 0);
    cyc(); settle(); chk_a("op3_hold", 1, 0, 0, 0);

    // Operand change while ready: ready drops in the same cycle.
    cyc(); in_bus = 16'h4321; settle(); chk_a("cwr_chg", 0, 0, 1, 3);
    cyc(); settle(); chk_a("cwr_e1", 0, 0, 1, 2);
    cyc(); settle(); chk_a("cwr_e2", 0, 0, 1, 1);
    cyc(); settle(); chk_a("cwr_e3", 1, 1, 0, 0);
    cyc(); settle(); chk_a("cwr_hold", 1, 0, 0, 0);

    // Op switch 3 -> 1 at counter 2 restarts the count.
    cyc(); in_bus = 16'h5555; settle(); chk_a("sw_chg", 0, 0, 1, 3);
    cyc(); settle(); chk_a("sw_c1", 0, 0, 1, 2);
    cyc(); settle(); chk_a("sw_c2", 0, 0, 1, 1);
    cyc(); op = 2'd1; settle(); chk_a("sw_op1", 0, 0, 1, 1);
    cyc(); settle(); chk_a("sw_e1", 1, 1, 0, 0);

    // Back-to-back operand changes keep ready low.
    for (int i = 0; i < 5; i++) begin
      cyc(); in_bus = 16'h0A00 + 16'(i); settle(); chk_a("b2b", 0, 0, 1, 1);
    end
    cyc(); settle(); chk_a("b2b_end", 1, 1, 0, 0);

    // Enable dropped at counter 2 with op3.
    cyc(); op = 2'd3; settle(); chk_a("en_chg", 0, 0, 1, 3);
    cyc(); settle(); chk_a("en_c1", 0, 0, 1, 2);
    cyc(); settle(); chk_a("en_c2", 0, 0, 1, 1);
    cyc(); enable = 1'b0; settle(); chk_a("en_off", 0, 0, 0, 0);
    cyc(); settle(); chk_a("en_off_e1", 0, 0, 0, 0);
    // Re-enable with stable inputs: counter restarts from 0, ready in the fourth enabled cycle.
    cyc(); enable = 1'b1; settle(); chk_a("en_on_c0", 0, 0, 1, 3);
    cyc(); settle(); chk_a("en_on_c1", 0, 0, 1, 2);
    cyc(); settle(); chk_a("en_on_c2", 0, 0, 1, 1);
    cyc(); settle(); chk_a("en_on_c3", 1, 1, 0, 0);

    // Saturation on the 2-bit instance (every latency is 3).
    cyc(); in_bus = 16'h7777; settle(); chk_b("sat_chg", 0, 0, 1, 3);
    cyc(); settle(); chk_b("sat_e1", 0, 0, 1, 2);
    cyc(); settle(); chk_b("sat_e2", 0, 0, 1, 1);
    cyc(); settle(); chk_b("sat_e3", 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(); settle(); chk_b("sat_hold", 1, 0, 0, 0);
    end

    // Reset in the middle of a count wins over everything.
    cyc(); in_bus = 16'h8888; settle(); chk_a("mid_chg", 0, 0, 1, 3);
    cyc(); reset = 1'b0; settle(); chk_a("mid_rst", 0, 0, 0, 0); chk_b("mid_rst", 0, 0, 0, 0);
    cyc(); reset = 1'b1; settle(); chk_a("mid_rel", 0, 0, 1, 3);
    cyc(); settle(); chk_a("mid_rel_e1", 0, 0, 1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
